// File: rtl/jtag_tap_ir_dr.sv
// jtag_tap_ir_dr: IEEE 1149.1 TAP controller with a generic-width instruction
// register and an integrated data-register bank (BYPASS, IDCODE, USER).
//
// Ports:
//   TCK          clock; all state updates on its rising edge
//   TRST         synchronous active-high reset
//   TMS          test mode select
//   TDI          serial data in
//   TDO          serial data out (combinational from registered state)
//   TDO_EN       high in Shift-IR / Shift-DR
//   TAP_STATE    current TAP state, IEEE encoding
//   LATCH_IR     active instruction
//   USER_DR_IN   parallel value captured into the USER chain
//   USER_DR      USER register, loaded in Update-DR
//   USER_UPDATE  one-cycle pulse after USER_DR loads
module jtag_tap_ir_dr #(
   parameter int unsigned          IR_WIDTH     = 4,
   parameter logic [IR_WIDTH-1:0]  IR_CAPTURE   = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0]  IDCODE_OPC   = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0]  USER_OPC     = IR_WIDTH'(2),
   parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
   parameter int unsigned          USER_WIDTH   = 8
) (
   input  logic                  TCK,
   input  logic                  TRST,
   input  logic                  TMS,
   input  logic                  TDI,
   output logic                  TDO,
   output logic                  TDO_EN,
   output logic [3:0]            TAP_STATE,
   output logic [IR_WIDTH-1:0]   LATCH_IR,
   input  logic [USER_WIDTH-1:0] USER_DR_IN,
   output logic [USER_WIDTH-1:0] USER_DR,
   output logic                  USER_UPDATE
);

   localparam int unsigned         ID_WIDTH   = 32;
   localparam logic [IR_WIDTH-1:0] BYPASS_OPC = '1;

   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PAU_DR = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PAU_IR = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_e;

   tap_state_e            state;
   tap_state_e            state_nxt;
   logic [IR_WIDTH-1:0]   ir_shift;
   logic [IR_WIDTH-1:0]   latch_ir;
   logic                  bypass_reg;
   logic [ID_WIDTH-1:0]   id_shift;
   logic [USER_WIDTH-1:0] user_shift;
   logic [USER_WIDTH-1:0] user_dr;
   logic                  user_update;
   logic                  sel_idcode;
   logic                  sel_user;

   // DR select; all-ones beats IDCODE beats USER, anything else is BYPASS
   always_comb begin
      sel_idcode = 1'b0;
      sel_user   = 1'b0;
      if (latch_ir != BYPASS_OPC) begin
         if (latch_ir == IDCODE_OPC) begin
            sel_idcode = 1'b1;
         end else if (latch_ir == USER_OPC) begin
            sel_user = 1'b1;
         end
      end
   end

   // TAP next-state
   always_comb begin
      state_nxt = state;
      unique case (state)
         TLR:    state_nxt = TMS ? TLR    : RTI;
         RTI:    state_nxt = TMS ? SEL_DR : RTI;
         SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
         SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
         CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   // State register plus IR/DR actions taken on the edge leaving each state
   always_ff @(posedge TCK) begin
      if (TRST) begin
         state       <= TLR;
         ir_shift    <= '0;
         latch_ir    <= IDCODE_OPC;
         bypass_reg  <= 1'b0;
         id_shift    <= '0;
         user_shift  <= '0;
         user_dr     <= '0;
         user_update <= 1'b0;
      end else begin
         state       <= state_nxt;
         user_update <= 1'b0;
         // Entering or sitting in TLR keeps IDCODE as the active instruction
         if (state == TLR || state_nxt == TLR) begin
            latch_ir <= IDCODE_OPC;
         end
         case (state)
            CAP_IR: ir_shift <= IR_CAPTURE;
            SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
            UPD_IR: latch_ir <= ir_shift;
            CAP_DR: begin
               if (sel_idcode) begin
                  id_shift <= IDCODE_VALUE;
               end else if (sel_user) begin
                  user_shift <= USER_DR_IN;
               end else begin
                  bypass_reg <= 1'b0;
               end
            end
            SH_DR: begin
               if (sel_idcode) begin
                  id_shift <= {TDI, id_shift[ID_WIDTH-1:1]};
               end else if (sel_user) begin
                  // Shift form that also holds for a 1-bit USER chain
                  user_shift <= (user_shift >> 1)
                              | (USER_WIDTH'(TDI) << (USER_WIDTH - 1));
               end else begin
                  bypass_reg <= TDI;
               end
            end
            UPD_DR: begin
               if (sel_user) begin
                  user_dr     <= user_shift;
                  user_update <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Serial output from the active shift stage
   always_comb begin
      TDO = 1'b0;
      case (state)
         SH_IR: TDO = ir_shift[0];
         SH_DR: begin
            if (sel_idcode) begin
               TDO = id_shift[0];
            end else if (sel_user) begin
               TDO = user_shift[0];
            end else begin
               TDO = bypass_reg;
            end
         end
         default: ;
      endcase
   end

   assign TDO_EN      = (state == SH_IR) || (state == SH_DR);
   assign TAP_STATE   = state;
   assign LATCH_IR    = latch_ir;
   assign USER_DR     = user_dr;
   assign USER_UPDATE = user_update;

endmodule

// File: tb/tb_jtag_tap_ir_dr.sv
// Directed bench for jtag_tap_ir_dr with a queue of expected TDO bits.
module tb_jtag_tap_ir_dr;

   localparam int unsigned IR_W   = 4;
   localparam int unsigned USER_W = 8;

   logic              TCK = 1'b0;
   logic              TRST;
   logic              TMS;
   logic              TDI;
   logic              TDO;
   logic              TDO_EN;
   logic [3:0]        TAP_STATE;
   logic [IR_W-1:0]   LATCH_IR;
   logic [USER_W-1:0] USER_DR_IN;
   logic [USER_W-1:0] USER_DR;
   logic              USER_UPDATE;

   int n_assert = 0;
   int n_fail   = 0;
   bit exp_q[$];

   jtag_tap_ir_dr dut (
      .TCK         (TCK),
      .TRST        (TRST),
      .TMS         (TMS),
      .TDI         (TDI),
      .TDO         (TDO),
      .TDO_EN      (TDO_EN),
      .TAP_STATE   (TAP_STATE),
      .LATCH_IR    (LATCH_IR),
      .USER_DR_IN  (USER_DR_IN),
      .USER_DR     (USER_DR),
      .USER_UPDATE (USER_UPDATE)
   );

   always #5 TCK = ~TCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive inputs, take one rising edge, sample 1 time unit later
   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      #1;
   endtask

   task automatic push_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
   endtask

   // Shift n bits LSB-first, comparing TDO against the scoreboard before each edge
   task automatic shift(input string tag, input logic [31:0] din, input int n, input bit exit_last);
      for (int i = 0; i < n; i++) begin
         check({tag, "_en"}, 32'(TDO_EN), 32'd1);
         check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check({tag, "_tdo"}, 32'(TDO), 32'(exp_q.pop_front()));
         tick(exit_last && (i == n - 1), din[i]);
      end
   endtask

   // Full IR scan from RTI back to RTI
   task automatic scan_ir(input logic [IR_W-1:0] opc);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("ir_shift_state", 32'(TAP_STATE), 32'hA);
      push_bits(32'h1, 4);
      shift("ir", 32'(opc), 4, 1'b1);
      check("ir_exit_state", 32'(TAP_STATE), 32'h9);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check("ir_rti_state", 32'(TAP_STATE), 32'hC);
      check("latch_ir", 32'(LATCH_IR), 32'(opc));
   endtask

   task automatic enter_shdr();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("dr_shift_state", 32'(TAP_STATE), 32'h2);
   endtask

   task automatic finish_dr();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check("dr_rti_state", 32'(TAP_STATE), 32'hC);
   endtask

   initial begin
      TRST = 1'b1;
      TMS = 1'b0;
      TDI = 1'b0;
      USER_DR_IN = '0;

      // Reset
      @(posedge TCK);
      #1;
      check("rst_state", 32'(TAP_STATE), 32'hF);
      check("rst_latch_ir", 32'(LATCH_IR), 32'h1);
      check("rst_user_dr", 32'(USER_DR), 32'h0);
      check("rst_tdo_en", 32'(TDO_EN), 32'h0);
      check("rst_user_update", 32'(USER_UPDATE), 32'h0);
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      check("rti_state", 32'(TAP_STATE), 32'hC);
      check("rti_latch_ir", 32'(LATCH_IR), 32'h1);

      // IR scan loads USER opcode; TDO shows the capture pattern
      scan_ir(4'b0010);

      // IDCODE after reset
      TRST = 1'b1;
      tick(1'b0, 1'b0);
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      enter_shdr();
      push_bits(32'h1000_0001, 32);
      shift("idcode", 32'h0, 32, 1'b1);
      finish_dr();
      check("idcode_latch_ir", 32'(LATCH_IR), 32'h1);

      // BYPASS: one-bit delay, captured 0 first
      scan_ir(4'b1111);
      check("byp_tdo_en_rti", 32'(TDO_EN), 32'h0);
      enter_shdr();
      exp_q.push_back(1'b0);
      push_bits(32'b1101, 3);
      shift("bypass", 32'b1101, 4, 1'b1);
      check("byp_tdo_en_exit", 32'(TDO_EN), 32'h0);
      finish_dr();

      // Undefined opcode behaves as BYPASS
      scan_ir(4'b0101);
      enter_shdr();
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      shift("undef", 32'b11, 2, 1'b1);
      finish_dr();

      // USER capture/update with a pause in the middle
      USER_DR_IN = 8'h3C;
      scan_ir(4'b0010);
      enter_shdr();
      push_bits(32'h3C, 8);
      shift("user_lo", 32'h5, 4, 1'b1);
      tick(1'b0, 1'b0);
      check("pause_state", 32'(TAP_STATE), 32'h3);
      check("pause_tdo_en", 32'(TDO_EN), 32'h0);
      check("pause_tdo", 32'(TDO), 32'h0);
      USER_DR_IN = 8'hFF;
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      check("ex2_state", 32'(TAP_STATE), 32'h0);
      tick(1'b0, 1'b0);
      shift("user_hi", 32'hA, 4, 1'b1);
      tick(1'b1, 1'b0);
      check("upd_state", 32'(TAP_STATE), 32'h5);
      check("upd_user_update", 32'(USER_UPDATE), 32'h0);
      check("upd_user_dr", 32'(USER_DR), 32'h0);
      tick(1'b0, 1'b0);
      check("user_dr", 32'(USER_DR), 32'hA5);
      check("user_update_pulse", 32'(USER_UPDATE), 32'h1);
      tick(1'b0, 1'b0);
      check("user_update_drop", 32'(USER_UPDATE), 32'h0);

      // Five TMS=1 from mid-scan reach TLR; the pass through Update-DR
      // loads the partially shifted chain (3C shifted three times with 0s)
      USER_DR_IN = 8'h3C;
      enter_shdr();
      push_bits(32'h3C, 2);
      shift("rec", 32'h0, 2, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      check("rec_state", 32'(TAP_STATE), 32'hF);
      check("rec_latch_ir", 32'(LATCH_IR), 32'h1);
      check("rec_user_dr", 32'(USER_DR), 32'h07);
      tick(1'b0, 1'b0);

      // TRST mid-shift aborts: no update, registers return to reset values
      scan_ir(4'b0010);
      USER_DR_IN = 8'h5A;
      enter_shdr();
      push_bits(32'h5A, 3);
      shift("abort", 32'hFF, 3, 1'b0);
      TRST = 1'b1;
      tick(1'b0, 1'b1);
      check("abort_state", 32'(TAP_STATE), 32'hF);
      check("abort_latch_ir", 32'(LATCH_IR), 32'h1);
      check("abort_user_dr", 32'(USER_DR), 32'h0);
      check("abort_user_update", 32'(USER_UPDATE), 32'h0);
      check("abort_tdo_en", 32'(TDO_EN), 32'h0);
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      check("post_abort_state", 32'(TAP_STATE), 32'hC);
      check("sb_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
